multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_defs.sv | 30 +++
 rtl/alu_iter_unit.sv | 74 +++++++
 rtl/multicycle_alu.sv | 166 ++++++++++++++++
 tb/tb_multicycle_alu.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// alu_defs: constants and types shared by multicycle_alu and alu_iter_unit.
//   - opcode encodings (3-bit)
//   - top-level FSM state encoding
//   - operation selector for the iterative datapath
package alu_defs;

  localparam logic [2:0] OP_PASS = 3'b000;  // forward DATA2
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SRA  = 3'b110;
  localparam logic [2:0] OP_LSH  = 3'b111;  // logical shift, signed amount

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    IT_MUL = 3'd0,
    IT_ROR = 3'd1,
    IT_SRA = 3'd2,
    IT_SHL = 3'd3,
    IT_SHR = 3'd4
  } iter_op_t;

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: one-bit-per-cycle datapath for multiply, rotate and shifts.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           load operands, operation and iteration count
//   step            advance one iteration (held high while the FSM is BUSY)
//   op              iterative operation selector
//   mplier          multiplier (multiply only)
//   value           multiplicand, or value to shift/rotate
//   amount          number of iterations to run (>= 1 when started)
//   last            current step is the final one
//   step_result     value the operation holds once the current step completes
module alu_iter_unit
  import alu_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  iter_op_t         op,
  input  logic [WIDTH-1:0] mplier,
  input  logic [WIDTH-1:0] value,
  input  logic [AW-1:0]    amount,
  output logic             last,
  output logic [WIDTH-1:0] step_result
);

  iter_op_t         op_reg;
  logic [WIDTH-1:0] acc_reg, val_reg, mplier_reg;
  logic [AW-1:0]    count_reg;
  logic [WIDTH-1:0] acc_next, val_next;

  // Multiply: val_reg carries the multiplicand shifted left each step, and the
  // multiplier's LSB decides whether it is added into the accumulator.
  always_comb begin
    acc_next = acc_reg + (mplier_reg[0] ? val_reg : '0);
    val_next = val_reg;
    case (op_reg)
      IT_MUL:  val_next = val_reg << 1;
      IT_ROR:  val_next = {val_reg[0], val_reg[WIDTH-1:1]};
      IT_SRA:  val_next = {val_reg[WIDTH-1], val_reg[WIDTH-1:1]};
      IT_SHL:  val_next = val_reg << 1;
      IT_SHR:  val_next = val_reg >> 1;
      default: val_next = val_reg;
    endcase
    step_result = (op_reg == IT_MUL) ? acc_next : val_next;
  end

  assign last = (count_reg == AW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= IT_MUL;
      acc_reg    <= '0;
      val_reg    <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else if (start) begin
      op_reg     <= op;
      acc_reg    <= '0;
      val_reg    <= value;
      mplier_reg <= mplier;
      count_reg  <= amount;
    end else if (step) begin
      acc_reg    <= acc_next;
      val_reg    <= val_next;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg - AW'(1);
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: ALU with valid/ready handshakes. Pass/add/and/or and
// zero-amount shifts complete in one cycle; multiply, rotate and shifts run
// one bit per cycle in alu_iter_unit.
// Ports:
//   CLK, RESET_N           clock, asynchronous active-low reset
//   IN_VALID / IN_READY    request handshake (ready only in IDLE)
//   DATA1, DATA2, SELECT   operands and opcode (DATA1 is the shift amount)
//   OUT_VALID / OUT_READY  result handshake (valid only in DONE)
//   RESULT, ZERO           registered result and (DATA1+DATA2)==0 flag
//   BUSY                   iterative operation in progress
module multicycle_alu
  import alu_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int SELW  = 3
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [SELW-1:0]  SELECT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY
);

  localparam int LW = $clog2(WIDTH);
  localparam int AW = LW + 1;  // wide enough to hold WIDTH itself
  localparam logic [WIDTH:0] W_LIM = (WIDTH + 1)'(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg, zero_pend_reg;

  logic [2:0]       op;
  logic [WIDTH-1:0] sum, single_result;
  logic             sum_zero, accept, needs_iter;
  logic [WIDTH:0]   d1_ext, d1_neg, sra_mag, sgn_mag;
  logic [AW-1:0]    amount;
  iter_op_t         iter_op;
  logic             iter_last;
  logic [WIDTH-1:0] iter_result;

  assign op       = 3'(SELECT);
  assign sum      = DATA1 + DATA2;
  assign sum_zero = (sum == '0);
  assign accept   = (state_reg == ST_IDLE) && IN_VALID;

  // Shift amounts are computed one bit wider than the operand so that the
  // magnitude of the most negative DATA1 and the clamp value WIDTH both fit.
  assign d1_ext = {1'b0, DATA1};
  assign d1_neg = '0 - {DATA1[WIDTH-1], DATA1};

  always_comb begin
    sra_mag    = (d1_ext >= W_LIM) ? W_LIM : d1_ext;
    sgn_mag    = DATA1[WIDTH-1] ? ((d1_neg >= W_LIM) ? W_LIM : d1_neg) : sra_mag;
    amount     = '0;
    iter_op    = IT_MUL;
    needs_iter = 1'b0;
    case (op)
      OP_ROR: begin
        iter_op = IT_ROR;
        amount  = AW'(DATA1[LW-1:0]);
      end
      OP_MUL: begin
        iter_op = IT_MUL;
        amount  = AW'(WIDTH);
      end
      OP_SRA: begin
        iter_op = IT_SRA;
        amount  = AW'(sra_mag);
      end
      OP_LSH: begin
        iter_op = DATA1[WIDTH-1] ? IT_SHR : IT_SHL;
        amount  = AW'(sgn_mag);
      end
      default: begin
        iter_op = IT_MUL;
        amount  = '0;
      end
    endcase
    // Only shift-class opcodes produce a nonzero amount; multiply always does.
    needs_iter = (amount != '0);
  end

  // A shift or rotate by zero leaves DATA2 untouched, hence the default.
  always_comb begin
    case (op)
      OP_PASS: single_result = DATA2;
      OP_ADD:  single_result = sum;
      OP_AND:  single_result = DATA1 & DATA2;
      OP_OR:   single_result = DATA1 | DATA2;
      default: single_result = DATA2;
    endcase
  end

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_iter (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .start       (accept && needs_iter),
    .step        (state_reg == ST_BUSY),
    .op          (iter_op),
    .mplier      (DATA1),
    .value       (DATA2),
    .amount      (amount),
    .last        (iter_last),
    .step_result (iter_result)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    IN_READY   = 1'b0;
    OUT_VALID  = 1'b0;
    BUSY       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_next = needs_iter ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        BUSY = 1'b1;
        if (iter_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // RESULT/ZERO load only on the edge that enters DONE; the zero flag of an
  // iterative operation is captured at acceptance and held until then.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      zero_pend_reg <= 1'b0;
    end else begin
      if (accept) zero_pend_reg <= sum_zero;
      if (accept && !needs_iter) begin
        result_reg <= single_result;
        zero_reg   <= sum_zero;
      end else if (state_reg == ST_BUSY && iter_last) begin
        result_reg <= iter_result;
        zero_reg   <= zero_pend_reg;
      end
    end
  end

  assign RESULT = result_reg;
  assign ZERO   = zero_reg;

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         IN_VALID, IN_READY;
  logic [W-1:0] DATA1, DATA2;
  logic [2:0]   SELECT;
  logic         OUT_VALID, OUT_READY;
  logic [W-1:0] RESULT;
  logic         ZERO, BUSY;

  int checks = 0;
  int errors = 0;

  logic         exp_valid = 1'b0;
  logic [W-1:0] exp_result;
  logic         exp_zero;

  multicycle_alu #(.WIDTH(W), .SELW(3)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .DATA1     (DATA1),
    .DATA2     (DATA2),
    .SELECT    (SELECT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .RESULT    (RESULT),
    .ZERO      (ZERO),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour from the opcode definitions, in plain integer arithmetic.
  function automatic void model(input logic [7:0] d1, input logic [7:0] d2, input logic [2:0] sel,
                                output logic [7:0] r, output logic z, output int lat);
    int k, a, v;
    z = (((int'(d1) + int'(d2)) % 256) == 0);
    lat = 1;
    r = d2;
    case (sel)
      3'd0: r = d2;
      3'd1: r = 8'((int'(d1) + int'(d2)) & 255);
      3'd2: r = d1 & d2;
      3'd3: r = d1 | d2;
      3'd4: begin
        k = int'(d1) % 8;
        r = 8'(((int'(d2) >> k) | (int'(d2) << (8 - k))) & 255);
        lat = k + 1;
      end
      3'd5: begin
        r = 8'((int'(d1) * int'(d2)) & 255);
        lat = 9;
      end
      3'd6: begin
        k = (int'(d1) > 8) ? 8 : int'(d1);
        v = int'($signed(d2));
        r = 8'((v >>> k) & 255);
        lat = k + 1;
      end
      default: begin
        a = int'($signed(d1));
        if (a >= 0) begin
          k = (a > 8) ? 8 : a;
          r = 8'((int'(d2) << k) & 255);
        end else begin
          k = (-a > 8) ? 8 : -a;
          r = 8'(int'(d2) >> k);
        end
        lat = k + 1;
      end
    endcase
  endfunction

  // Every cycle a result is presented it must match the outstanding expectation.
  always @(negedge CLK) begin
    if (RESET_N && OUT_VALID) begin
      if (!exp_valid) begin
        check("spurious_out_valid", 32'(OUT_VALID), 32'(0));
      end else begin
        check("result", 32'(RESULT), 32'(exp_result));
        check("zero", 32'(ZERO), 32'(exp_zero));
      end
    end
  end

  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic run_op(input logic [7:0] d1, input logic [7:0] d2, input logic [2:0] sel,
                        input int hold, output logic [7:0] r_cap, output logic z_cap);
    int lat, busy_cyc, exp_lat;
    logic [7:0] mr;
    logic mz;
    model(d1, d2, sel, mr, mz, exp_lat);
    check("in_ready_idle", 32'(IN_READY), 32'(1));
    exp_result = mr;
    exp_zero   = mz;
    exp_valid  = 1'b1;
    DATA1 = d1; DATA2 = d2; SELECT = sel; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    lat = 1;
    busy_cyc = 0;
    while (!OUT_VALID && lat < 40) begin
      if (BUSY) busy_cyc++;
      IN_VALID = 1'($urandom);
      DATA1 = 8'($urandom); DATA2 = 8'($urandom); SELECT = 3'($urandom);
      @(posedge CLK); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(busy_cyc), 32'(exp_lat - 1));
    r_cap = RESULT;
    z_cap = ZERO;
    OUT_READY = 1'b0;
    for (int h = 0; h < hold; h++) begin
      check("in_ready_done", 32'(IN_READY), 32'(0));
      IN_VALID = 1'($urandom);
      DATA1 = 8'($urandom); DATA2 = 8'($urandom); SELECT = 3'($urandom);
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    exp_valid = 1'b0;
    check("out_valid_cleared", 32'(OUT_VALID), 32'(0));
    $display("op=%0d d1=%02h d2=%02h -> result=%02h zero=%0b lat=%0d", sel, d1, d2, r_cap, z_cap, lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, 32'(RESULT), 32'(0));
    check({tag, "_zero"}, 32'(ZERO), 32'(0));
    check({tag, "_out_valid"}, 32'(OUT_VALID), 32'(0));
    check({tag, "_busy"}, 32'(BUSY), 32'(0));
    check({tag, "_in_ready"}, 32'(IN_READY), 32'(1));
  endtask

  typedef struct {
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] sel;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t vecs[] = '{
    '{8'h01, 8'h03, 3'd1, 8'h04, 1'b0},  // add
    '{8'h81, 8'h7F, 3'd1, 8'h00, 1'b1},  // add wraps to zero
    '{8'hD5, 8'hEA, 3'd2, 8'hC0, 1'b0},  // and
    '{8'h0D, 8'h0B, 3'd5, 8'h8F, 1'b0},  // multiply
    '{8'h03, 8'h81, 3'd4, 8'h30, 1'b0},  // rotate right 3
    '{8'h0B, 8'h81, 3'd4, 8'h30, 1'b0},  // rotate amount 11 -> 3
    '{8'h02, 8'h90, 3'd6, 8'hE4, 1'b0},  // sra 2
    '{8'hFE, 8'h90, 3'd7, 8'h24, 1'b0},  // signed shift -2 -> right 2
    '{8'h20, 8'h90, 3'd6, 8'hFF, 1'b0},  // sra clamped
    '{8'h80, 8'h90, 3'd7, 8'h00, 1'b0},  // -128 clamped -> zeros
    '{8'h03, 8'h90, 3'd7, 8'h80, 1'b0},  // left 3
    '{8'h08, 8'h5A, 3'd4, 8'h5A, 1'b0}   // rotate by 8 == 0, single cycle
  };

  initial begin
    logic [7:0] r;
    logic       z;
    RESET_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    DATA1 = '0; DATA2 = '0; SELECT = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].d1, vecs[i].d2, vecs[i].sel, (i == 0) ? 5 : 0, r, z);
      check("directed_result", 32'(r), 32'(vecs[i].r));
      check("directed_zero", 32'(z), 32'(vecs[i].z));
    end

    // Reset in the middle of a multiply abandons it.
    exp_valid = 1'b0;
    DATA1 = 8'h0D; DATA2 = 8'h0B; SELECT = 3'd5; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("mul_busy_before_reset", 32'(BUSY), 32'(1));
    RESET_N = 1'b0;
    #1;
    check_reset_outputs("midmul");
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    check("no_valid_after_abort", 32'(OUT_VALID), 32'(0));
    run_op(8'h01, 8'h03, 3'd1, 0, r, z);
    check("add_after_reset", 32'(r), 32'(8'h04));

    // Randomized traffic, biased toward small and boundary shift amounts.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] d1;
      logic [2:0] sel;
      sel = 3'($urandom);
      case ($urandom_range(0, 3))
        0: d1 = 8'($urandom_range(0, 9));
        1: d1 = 8'(-$urandom_range(0, 9));
        2: d1 = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h7F;
        default: d1 = 8'($urandom);
      endcase
      run_op(d1, 8'($urandom), sel, $urandom_range(0, 3), r, z);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
